clk_div_cfg_ctrl: RTL and testbench

Control front-end for the integer clock divider (clk_int_div_simple). It accepts divider-change requests from the CSR side over a valid/ready handshake and holds the divider value in a register, as the divider requires. It gates the divided clock off around the switch, issues the divider load handshake, and waits for div_done with a timeout. It then re-enables the clock and reports status.

---
 rtl/clk_div_cfg_pkg.sv | 17 +
 rtl/clk_div_cfg_ctrl_dly_cnt.sv | 44 ++++
 rtl/dffr.sv | 22 ++
 rtl/clk_div_cfg_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_cfg_pkg.sv
// Shared types and default widths for the clock-divider configuration controller.
package clk_div_cfg_pkg;

    localparam int unsigned DIV_VALUE_WIDTH_DEF = 32;
    localparam int unsigned GATE_DLY_WIDTH_DEF  = 4;
    localparam int unsigned TIMEOUT_WIDTH_DEF   = 16;
    localparam int unsigned STATE_WIDTH         = 3;

    typedef enum logic [2:0] {
        IDLE,
        GATE_OFF,
        LOAD,
        WAIT_DONE,
        GATE_ON
    } clk_div_cfg_state_e;

endpackage

// File: rtl/clk_div_cfg_ctrl_dly_cnt.sv
// Loadable saturating counter: counts down to 0 or up to all-ones, then holds.
//   load_i/load_val_i : synchronous load (wins over enable)
//   en_i              : count one step toward the terminal value
//   term_o            : counter sits at its terminal value
module clk_dly_cnt #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          COUNT_UP = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             term_o
);

    localparam logic [WIDTH-1:0] TERM_VAL = COUNT_UP ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign term_o = (cnt_q == TERM_VAL);

    // Next count: load first, otherwise step unless already at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !term_o) begin
            cnt_d = COUNT_UP ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
        end
    end

    dffr #(
        .WIDTH   (WIDTH),
        .RST_VAL ({WIDTH{1'b0}})
    ) u_cnt_reg (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (cnt_d),
        .q_o     (cnt_q)
    );

endmodule

// File: rtl/dffr.sv
// Generic D flip-flop with asynchronous active-low reset to a parameterised value.
//   clk_i, rst_n_i : clock, async active-low reset
//   d_i / q_o      : next / current value
module dffr #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Divider-change controller: accepts a CSR request, gates the divided clock off,
// loads the divider, waits for done (with timeout), then re-enables the clock.
//   cfg_*_i / cfg_ready_o      : request handshake and captured settings
//   div_o, clk_init_o,
//   div_valid_o / div_ready_i,
//   div_done_i                 : divider load interface
//   clk_en_o                   : enable for the downstream clock gate
//   busy_o, err_timeout_o,
//   err_clr_i                  : status and sticky-error clear
module clk_div_cfg_ctrl
    import clk_div_cfg_pkg::*;
#(
    parameter int unsigned DIV_VALUE_WIDTH = DIV_VALUE_WIDTH_DEF,
    parameter int unsigned GATE_DLY_WIDTH  = GATE_DLY_WIDTH_DEF,
    parameter int unsigned TIMEOUT_WIDTH   = TIMEOUT_WIDTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
    input  logic                       cfg_init_i,
    input  logic [GATE_DLY_WIDTH-1:0]  cfg_gate_dly_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       clk_init_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    input  logic                       div_done_i,
    output logic                       clk_en_o,
    output logic                       busy_o,
    output logic                       err_timeout_o,
    input  logic                       err_clr_i
);

    clk_div_cfg_state_e state_q, state_d;
    logic [STATE_WIDTH-1:0] state_raw_q;

    logic [DIV_VALUE_WIDTH-1:0] pend_div_q, pend_div_d;
    logic                       pend_init_q, pend_init_d;
    logic [GATE_DLY_WIDTH-1:0]  pend_dly_q, pend_dly_d;
    logic [DIV_VALUE_WIDTH-1:0] div_q, div_d;
    logic                       init_q, init_d;
    logic                       err_q, err_d;
    logic                       done_armed_q;

    logic                      gate_load, gate_en, gate_term;
    logic [GATE_DLY_WIDTH-1:0] gate_load_val;
    logic                      tmo_load, tmo_en, tmo_term, tmo_set;

    // Next-state, counter control and register next values.
    always_comb begin
        state_d       = state_q;
        pend_div_d    = pend_div_q;
        pend_init_d   = pend_init_q;
        pend_dly_d    = pend_dly_q;
        div_d         = div_q;
        init_d        = init_q;
        gate_load     = 1'b0;
        gate_load_val = pend_dly_q;
        gate_en       = 1'b0;
        tmo_load      = 1'b0;
        tmo_en        = 1'b0;
        tmo_set       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    pend_div_d    = cfg_div_i;
                    pend_init_d   = cfg_init_i;
                    pend_dly_d    = cfg_gate_dly_i;
                    gate_load     = 1'b1;
                    gate_load_val = cfg_gate_dly_i;
                    state_d       = GATE_OFF;
                end
            end
            GATE_OFF: begin
                gate_en = 1'b1;
                if (gate_term) begin
                    div_d   = pend_div_q;
                    init_d  = pend_init_q;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (div_ready_i) begin
                    tmo_load = 1'b1;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tmo_en = 1'b1;
                // The divider's done flag is stale in the first cycle after the handshake.
                if (done_armed_q && div_done_i) begin
                    gate_load = 1'b1;
                    state_d   = GATE_ON;
                end else if (tmo_term) begin
                    tmo_set   = 1'b1;
                    gate_load = 1'b1;
                    state_d   = GATE_ON;
                end
            end
            GATE_ON: begin
                gate_en = 1'b1;
                if (gate_term) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle timeout wins over a clear.
    assign err_d = tmo_set | (err_q & ~err_clr_i);

    dffr #(
        .WIDTH   (STATE_WIDTH),
        .RST_VAL (STATE_WIDTH'(IDLE))
    ) u_state_reg (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (STATE_WIDTH'(state_d)),
        .q_o     (state_raw_q)
    );

    assign state_q = clk_div_cfg_state_e'(state_raw_q);

    // Pending request, divider outputs, sticky error and done-arming flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_div_q   <= '0;
            pend_init_q  <= 1'b0;
            pend_dly_q   <= '0;
            div_q        <= '0;
            init_q       <= 1'b0;
            err_q        <= 1'b0;
            done_armed_q <= 1'b0;
        end else begin
            pend_div_q   <= pend_div_d;
            pend_init_q  <= pend_init_d;
            pend_dly_q   <= pend_dly_d;
            div_q        <= div_d;
            init_q       <= init_d;
            err_q        <= err_d;
            done_armed_q <= (state_q == WAIT_DONE);
        end
    end

    clk_dly_cnt #(
        .WIDTH    (GATE_DLY_WIDTH),
        .COUNT_UP (1'b0)
    ) u_gate_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (gate_load),
        .load_val_i (gate_load_val),
        .en_i       (gate_en),
        .term_o     (gate_term)
    );

    clk_dly_cnt #(
        .WIDTH    (TIMEOUT_WIDTH),
        .COUNT_UP (1'b1)
    ) u_tmo_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmo_load),
        .load_val_i ({TIMEOUT_WIDTH{1'b0}}),
        .en_i       (tmo_en),
        .term_o     (tmo_term)
    );

    // Status and handshake outputs decode straight from the registered state.
    assign cfg_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign clk_en_o      = (state_q == IDLE);
    assign div_valid_o   = (state_q == LOAD);
    assign div_o         = div_q;
    assign clk_init_o    = init_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: a default-width instance for the switch,
// back-pressure, stale-done and reset sequences, and a 4-bit-timeout instance.
module tb_clk_div_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_div;
    logic        cfg_init;
    logic [3:0]  cfg_dly;
    logic        cfg_valid, div_ready, div_done, err_clr;
    logic        ready, clk_init, div_valid, clk_en, busy, err;
    logic [31:0] div_o;

    logic        t_valid, t_err_clr;
    logic        t_ready, t_init, t_div_valid, t_clk_en, t_busy, t_err;
    logic [31:0] t_div;
    logic        t_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_div_cfg_ctrl u_dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cfg_div_i      (cfg_div),
        .cfg_init_i     (cfg_init),
        .cfg_gate_dly_i (cfg_dly),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (ready),
        .div_o          (div_o),
        .clk_init_o     (clk_init),
        .div_valid_o    (div_valid),
        .div_ready_i    (div_ready),
        .div_done_i     (div_done),
        .clk_en_o       (clk_en),
        .busy_o         (busy),
        .err_timeout_o  (err),
        .err_clr_i      (err_clr)
    );

    clk_div_cfg_ctrl #(.TIMEOUT_WIDTH(4)) u_dut_tmo (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cfg_div_i      (cfg_div),
        .cfg_init_i     (cfg_init),
        .cfg_gate_dly_i (cfg_dly),
        .cfg_valid_i    (t_valid),
        .cfg_ready_o    (t_ready),
        .div_o          (t_div),
        .clk_init_o     (t_init),
        .div_valid_o    (t_div_valid),
        .div_ready_i    (div_ready),
        .div_done_i     (t_done),
        .clk_en_o       (t_clk_en),
        .busy_o         (t_busy),
        .err_timeout_o  (t_err),
        .err_clr_i      (t_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: through the active edge, then park on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_div   = '0;
        cfg_init  = 1'b0;
        cfg_dly   = '0;
        cfg_valid = 1'b0;
        div_ready = 1'b1;
        div_done  = 1'b0;
        err_clr   = 1'b0;
        t_valid   = 1'b0;
        t_err_clr = 1'b0;
        t_done    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_div",   div_o,     32'd0);
        chk("rst_clken", clk_en,    1);
        chk("rst_ready", ready,     1);
        chk("rst_busy",  busy,      0);
        chk("rst_err",   err,       0);
        chk("rst_valid", div_valid, 0);
        chk("rst_t_err", t_err,     0);

        // Normal switch: div=3, gate delay 2
        cfg_div = 32'd3; cfg_init = 1'b1; cfg_dly = 4'd2; cfg_valid = 1'b1;
        chk("n_ready_pre", ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("n_clken_c1", clk_en, 0);
        chk("n_busy_c1",  busy,   1);
        chk("n_ready_c1", ready,  0);
        tick();
        chk("n_clken_c2", clk_en, 0);
        tick();
        chk("n_clken_c3", clk_en,    0);
        chk("n_valid_c3", div_valid, 0);
        tick();
        chk("n_valid_c4", div_valid, 1);
        chk("n_div_c4",   div_o,     32'd3);
        chk("n_init_c4",  clk_init,  1);
        tick();
        chk("n_valid_w1", div_valid, 0);

        // Back-pressure: second request while busy
        cfg_div = 32'd7; cfg_init = 1'b0; cfg_dly = 4'd0; cfg_valid = 1'b1;
        chk("bp_ready", ready, 0);
        repeat (19) tick();
        chk("bp_div_w20",  div_o, 32'd3);
        chk("bp_busy_w20", busy,  1);
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        chk("n_clken_g1", clk_en, 0);
        tick();
        chk("n_clken_g2", clk_en, 0);
        tick();
        chk("n_clken_g3", clk_en, 0);
        tick();
        chk("n_clken_idle", clk_en, 1);
        chk("n_ready_idle", ready,  1);
        chk("bp_div_idle",  div_o,  32'd3);
        tick();
        cfg_valid = 1'b0;
        chk("bp_busy_acc",  busy,   1);
        chk("bp_clken_off", clk_en, 0);
        tick();
        chk("bp_valid", div_valid, 1);
        chk("bp_div",   div_o,     32'd7);
        chk("bp_init",  clk_init,  0);

        // Stale done held high from the load cycle on
        div_done = 1'b1;
        tick();
        tick();
        chk("st_busy_w2", busy, 1);
        tick();
        chk("st_busy_g1",  busy,   1);
        chk("st_clken_g1", clk_en, 0);
        tick();
        chk("st_ready_idle", ready,  1);
        chk("st_clken_idle", clk_en, 1);
        div_done = 1'b0;

        // Timeout on the 4-bit-timeout instance, done never arrives
        cfg_div = 32'd5; cfg_dly = 4'd1; t_valid = 1'b1;
        chk("to_ready", t_ready, 1);
        tick();
        t_valid = 1'b0;
        tick();
        tick();
        chk("to_valid", t_div_valid, 1);
        chk("to_div",   t_div,       32'd5);
        tick();
        repeat (15) tick();
        chk("to_err_w16",  t_err,  0);
        chk("to_busy_w16", t_busy, 1);
        tick();
        chk("to_err_g1",   t_err,    1);
        chk("to_clken_g1", t_clk_en, 0);
        tick();
        chk("to_busy_g2", t_busy, 1);
        tick();
        chk("to_clken_idle", t_clk_en, 1);
        chk("to_ready_idle", t_ready,  1);
        chk("to_err_sticky", t_err,    1);
        t_err_clr = 1'b1;
        tick();
        t_err_clr = 1'b0;
        chk("to_err_clr", t_err, 0);

        // Reset in the middle of WAIT_DONE
        cfg_div = 32'd9; cfg_dly = 4'd0; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("rs_busy_w1", busy,  1);
        chk("rs_div_w1",  div_o, 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_div",   div_o,     32'd0);
        chk("rs_valid", div_valid, 0);
        chk("rs_clken", clk_en,    1);
        chk("rs_busy",  busy,      0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero gate delay after reset: one-cycle gate phases
        cfg_div = 32'd2; cfg_dly = 4'd0; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("z_clken_off", clk_en,    0);
        chk("z_valid_off", div_valid, 0);
        tick();
        chk("z_valid", div_valid, 1);
        chk("z_div",   div_o,     32'd2);
        tick();
        div_done = 1'b1;
        tick();
        chk("z_busy_w2", busy, 1);
        tick();
        div_done = 1'b0;
        chk("z_busy_g1",  busy,   1);
        chk("z_clken_g1", clk_en, 0);
        tick();
        chk("z_clken_idle", clk_en, 1);
        chk("z_ready_idle", ready,  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
